// File: rtl/alu_iterative_exec_if.sv
// Handshake bundle between the ALU control decoder, the iterative ALU and its consumer.
// The master side issues operations and takes results; the slave side is the ALU itself.
interface alu_iterative_exec_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, alu_control, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, alu_control, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, busy
    );
endinterface

// File: rtl/alu_iterative_exec.sv
// Execute-stage ALU. Single-cycle add/sub/and/or/slt; shifts walk one bit per cycle
// through the result register. One operation in flight, valid/ready on both sides.
module alu_iterative_exec #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_iterative_exec_if.slave  bus
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpSlt = 3'b100;
    localparam logic [2:0] OpSll = 3'b101;
    localparam logic [2:0] OpSrl = 3'b110;
    localparam logic [2:0] OpSra = 3'b111;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t               state_q;
    logic [2:0]           op_q;
    logic [SHAMT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]     result_q;
    logic                 zero_q;
    logic                 out_valid_q;
    logic                 busy_q;

    logic [SHAMT_W-1:0]   shamt;
    logic                 is_shift;
    logic [WIDTH-1:0]     alu_res;
    logic [WIDTH-1:0]     shift_step;

    assign shamt    = bus.src_b[SHAMT_W-1:0];
    assign is_shift = (bus.alu_control == OpSll) || (bus.alu_control == OpSrl) ||
                      (bus.alu_control == OpSra);

    // Single-cycle result for the incoming op; a zero-distance shift passes src_a through.
    always_comb begin
        alu_res = '0;
        unique case (bus.alu_control)
            OpAdd:   alu_res = bus.src_a + bus.src_b;
            OpSub:   alu_res = bus.src_a - bus.src_b;
            OpAnd:   alu_res = bus.src_a & bus.src_b;
            OpOr:    alu_res = bus.src_a | bus.src_b;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
            default: alu_res = bus.src_a;
        endcase
    end

    // One-bit shift of the accumulator for the captured shift op.
    always_comb begin
        shift_step = result_q;
        unique case (op_q)
            OpSll:   shift_step = {result_q[WIDTH-2:0], 1'b0};
            OpSrl:   shift_step = {1'b0, result_q[WIDTH-1:1]};
            OpSra:   shift_step = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            default: shift_step = result_q;
        endcase
    end

    // Control FSM with registered outputs; result_q doubles as the shift accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= OpAdd;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        op_q   <= bus.alu_control;
                        busy_q <= 1'b1;
                        if (is_shift && (shamt != '0)) begin
                            state_q  <= StShift;
                            result_q <= bus.src_a;
                            cnt_q    <= shamt;
                        end else begin
                            state_q     <= StDone;
                            result_q    <= alu_res;
                            zero_q      <= (alu_res == '0);
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                StShift: begin
                    result_q <= shift_step;
                    cnt_q    <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_q     <= StDone;
                        zero_q      <= (shift_step == '0);
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_iterative_exec.sv
// Directed bench for alu_iterative_exec: hand-computed vectors, latency, stall and reset.
module tb_alu_iterative_exec;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_iterative_exec_if #(.WIDTH(32)) bus ();

    alu_iterative_exec #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op with out_ready high and check result, zero, latency and return to idle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.alu_control = op;
        bus.src_a       = a;
        bus.src_b       = b;
        bus.out_ready   = 1'b1;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_result"}, bus.result, exp);
        chk({tag, "_zero"}, 32'(bus.zero), 32'(exp == 32'd0));
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.alu_control = 3'b000;
        bus.src_a       = '0;
        bus.src_b       = '0;
        bus.out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_zero_busy", {30'd0, bus.zero, bus.busy}, 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add", 3'b000, 32'd5, 32'd7, 32'd12, 1);
        run_op("sub_eq", 3'b001, 32'd9, 32'd9, 32'd0, 1);
        run_op("sub_wrap", 3'b001, 32'd0, 32'd1, 32'hFFFF_FFFF, 1);
        run_op("slt_neg", 3'b100, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        run_op("slt_pos", 3'b100, 32'd1, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("and", 3'b010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1);
        run_op("or", 3'b011, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 1);
        run_op("sra4", 3'b111, 32'h8000_0000, 32'd4, 32'hF800_0000, 5);
        run_op("srl4", 3'b110, 32'h8000_0000, 32'd4, 32'h0800_0000, 5);
        run_op("sll31", 3'b101, 32'd1, 32'd31, 32'h8000_0000, 32);
        run_op("srl_b25", 3'b110, 32'hFFFF_FFFF, 32'h25, 32'h07FF_FFFF, 6);
        run_op("sll_sh0", 3'b101, 32'h0000_1234, 32'd0, 32'h0000_1234, 1);
        run_op("sra_b20", 3'b111, 32'h8000_0001, 32'h20, 32'h8000_0001, 1);
        run_op("srl_zero", 3'b110, 32'd1, 32'd1, 32'd0, 2);

        // Stall in DONE for 3 cycles while a second request is presented.
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.alu_control = 3'b000;
        bus.src_a       = 32'd3;
        bus.src_b       = 32'd4;
        bus.out_ready   = 1'b0;
        @(posedge clk);
        #1;
        bus.alu_control = 3'b010;
        bus.src_a       = 32'h0000_F0F0;
        bus.src_b       = 32'h0000_FF00;
        for (int i = 0; i < 3; i++) begin
            chk("stall_result", bus.result, 32'd7);
            chk("stall_flags", {29'd0, bus.out_valid, bus.zero, bus.in_ready}, 32'b100);
            @(posedge clk);
            #1;
        end
        chk("stall_held", {bus.result[29:0], bus.out_valid, bus.in_ready}, {30'd7, 2'b10});
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("next_valid", 32'(bus.out_valid), 32'd1);
        chk("next_result", bus.result, 32'h0000_F000);
        @(posedge clk);
        #1;

        // Reset while shifting: sll by 20, reset on the 7th cycle after accept.
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.alu_control = 3'b101;
        bus.src_a       = 32'd1;
        bus.src_b       = 32'd20;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_shift_busy", {30'd0, bus.busy, bus.out_valid}, 32'b10);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin
            @(posedge clk);
            #1;
            chk("post_rst_quiet", 32'(bus.out_valid), 32'd0);
        end
        run_op("add_after_rst", 3'b000, 32'd2, 32'd3, 32'd5, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
